// File: rtl/neurosa_pkg.sv
// neurosa_pkg: shared event packing constants for the spike network, event queue and neuron update stage
package neurosa_pkg;
  localparam int TEN_DATA_W  = 2;
  localparam int NEURON_ID_W = 7;
  localparam int EVENT_W     = TEN_DATA_W + NEURON_ID_W;
  localparam int ID_LSB      = 0;
  localparam int SPIKE_LSB   = NEURON_ID_W;
endpackage

// File: rtl/spike_event_queue.sv
// spike_event_queue: first-word-fall-through spike event FIFO with drop detection; SPIKE_QUEUE_DROP_CNT_EN adds drop_cnt
module spike_event_queue
  import neurosa_pkg::*;
#(
  parameter int TEN_DATA_WIDTH  = TEN_DATA_W,
  parameter int NEURON_ID_WIDTH = NEURON_ID_W,
  parameter int QUEUE_DEPTH     = 8
) (
  input  logic                                      clk,
  input  logic                                      reset_l,
  input  logic                                      en_queue,
  input  logic                                      flush,
  input  logic                                      skip_zero,
  input  logic                                      ev_valid,
  input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] ev_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] out_data,
  output logic [$clog2(QUEUE_DEPTH):0]              count,
  output logic                                      full,
  output logic                                      empty,
  output logic                                      overflow
`ifdef SPIKE_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0]                                drop_cnt
`endif
);
  localparam int EW = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  logic [EW-1:0] mem_q [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          skip_ev, offer, push, pop, drop, flush_en;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(QUEUE_DEPTH);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign skip_ev   = skip_zero && ev_data[EW-1 -: TEN_DATA_WIDTH] == '0;
  assign offer     = en_queue && ev_valid && !flush && !skip_ev;
  assign pop       = en_queue && out_valid && out_ready && !flush;
  assign push      = offer && (!full || pop);
  assign drop      = offer && full && !pop;
  assign flush_en  = en_queue && flush;
  // next-state for pointers, occupancy and the sticky loss flag
  always_comb begin
    wr_ptr_d   = flush_en ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d   = flush_en ? '0 : rd_ptr_q + AW'(pop);
    count_d    = flush_en ? '0 : count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
  end
  // control state register, cleared asynchronously
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  // event storage is not reset; contents are meaningless while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ev_data;
  end
`ifdef SPIKE_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  assign drop_cnt = drop_cnt_q;
  // saturating count of events lost to a full queue
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
  end
`endif
endmodule

// File: tb/tb_spike_event_queue.sv
// tb_spike_event_queue: scoreboard bench for spike_event_queue; checks drop_cnt when SPIKE_QUEUE_DROP_CNT_EN is defined
module tb_spike_event_queue;
  logic       clk = 0, reset_l = 0, en_queue = 1, flush = 0, skip_zero = 0, ev_valid = 0, out_ready = 0;
  logic [8:0] ev_data = '0;
  logic       out_valid, full, empty, overflow;
  logic [8:0] out_data;
  logic [3:0] count;
`ifdef SPIKE_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  logic [8:0] exp_q [$];
  logic [8:0] exp_v;
  int ncmp = 0, nfail = 0;

  spike_event_queue dut (
    .clk(clk), .reset_l(reset_l), .en_queue(en_queue), .flush(flush), .skip_zero(skip_zero),
    .ev_valid(ev_valid), .ev_data(ev_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .full(full), .empty(empty), .overflow(overflow)
`ifdef SPIKE_QUEUE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [8:0] d, input bit accepted);
    ev_valid = 1;
    ev_data  = d;
    if (accepted) exp_q.push_back(d);
    step();
    ev_valid = 0;
  endtask

  // monitor: every head entry the DUT hands off must match the scoreboard front
  always @(negedge clk) begin
    if (reset_l && en_queue && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        exp_v = exp_q.pop_front();
        chk("pop_data", 32'(out_data), 32'(exp_v));
      end
    end
  end

  initial begin
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    #4 reset_l = 1;
    step();
    // single event
    push_ev(9'b01_0100101, 1);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'h0A5);
    chk("single_count", 32'(count), 1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("single_empty", 32'(empty), 1);
    // fill to 8 then overflow on the 9th
    for (int i = 0; i < 9; i++) begin
      push_ev({2'b10, 7'(i + 1)}, i < 8);
      if (i == 7) chk("fill_full", 32'(full), 1);
    end
    chk("fill_count", 32'(count), 8);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_head", 32'(out_data), 32'h101);
`ifdef SPIKE_QUEUE_DROP_CNT_EN
    chk("fill_dropcnt", 32'(drop_cnt), 1);
`endif
    // push and pop together while full
    out_ready = 1;
    push_ev(9'b11_1111111, 1);
    chk("pp_count", 32'(count), 8);
    chk("pp_full", 32'(full), 1);
`ifdef SPIKE_QUEUE_DROP_CNT_EN
    chk("pp_dropcnt", 32'(drop_cnt), 1);
`endif
    repeat (8) step();
    out_ready = 0;
    chk("drain_empty", 32'(empty), 1);
    // enable low holds everything
    for (int i = 0; i < 5; i++) push_ev({2'b01, 7'(i + 40)}, 1);
    en_queue = 0; ev_valid = 1; ev_data = 9'h1FF; out_ready = 1;
    step();
    chk("en_count", 32'(count), 5);
    chk("en_valid", 32'(out_valid), 1);
    chk("en_head", 32'(out_data), 32'(exp_q[0]));
    // flush with 5 entries, same-cycle push and pop ignored
    en_queue = 1; flush = 1;
    exp_q.delete();
    step();
    flush = 0; ev_valid = 0; out_ready = 0;
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 1);
    // only reset clears overflow
    reset_l = 0;
    #1;
    chk("rst2_ovf", 32'(overflow), 0);
    reset_l = 1;
    step();
    // skip_zero discards zero spikes without counting a drop
    skip_zero = 1;
    push_ev(9'b00_0000101, 0);
    chk("skip_count", 32'(count), 0);
    chk("skip_ovf", 32'(overflow), 0);
    skip_zero = 0;
    push_ev(9'b00_0000101, 1);
    chk("noskip_count", 32'(count), 1);
    chk("noskip_data", 32'(out_data), 32'h005);
    out_ready = 1;
    step();
    out_ready = 0;
    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) push_ev({2'b10, 7'(i + 90)}, 1);
    out_ready = 1;
    step();
    #2;
    reset_l = 0;
    exp_q.delete();
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    out_ready = 0;
    #3 reset_l = 1;
    step();
    chk("arst_empty", 32'(empty), 1);
    chk("sb_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/spike_event_queue.md
SPIKE_EVENT_QUEUE -- requirements
Module: spike_event_queue

Interface
REQ-001 SHALL have parameter TEN_DATA_WIDTH, default 2, the spike value width per event.
REQ-002 SHALL have parameter NEURON_ID_WIDTH, default 7, the neuron index width per event.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 8, the entry count (power of two, minimum 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_l, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en_queue, input, 1 bit: global stage enable; when low, no state changes.
REQ-007 SHALL have port flush, input, 1 bit: synchronous empty of the queue, qualified by en_queue.
REQ-008 SHALL have port skip_zero, input, 1 bit: when high, discard events whose spike value is 0.
REQ-009 SHALL have port ev_valid, input, 1 bit: event strobe from the upstream network done pulse.
REQ-010 SHALL have port ev_data, input, TEN_DATA_WIDTH+NEURON_ID_WIDTH bits: {spike value, neuron id}, spike value in the MSBs.
REQ-011 SHALL have port out_valid, output, 1 bit: head entry available.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-013 SHALL have port out_data, output, TEN_DATA_WIDTH+NEURON_ID_WIDTH bits: head entry, same packing as ev_data.
REQ-014 SHALL have port count, output, log2(QUEUE_DEPTH)+1 bits: number of occupied entries.
REQ-015 SHALL have ports full and empty, output, 1 bit each: occupancy flags.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag set when an event is lost.

Function
REQ-017 SHALL accept a push when en_queue && ev_valid && !flush && !(skip_zero && spike value==0) && (!full || pop).
REQ-018 SHALL perform a pop when en_queue && out_valid && out_ready && !flush.
REQ-019 SHALL be first-word-fall-through: out_data equals the head entry combinationally, and out_valid equals !empty.
REQ-020 SHALL, on a simultaneous push and pop, keep count unchanged; when full, the freed slot takes the new event, with no drop.
REQ-021 SHALL, on push while empty, raise out_valid on the next cycle, giving 1-cycle latency from ev_valid to out_valid.
REQ-022 SHALL, on push while full without pop, drop the event, leave contents unchanged, and set overflow.
REQ-023 SHALL wrap read and write pointers modulo QUEUE_DEPTH; full = (count==QUEUE_DEPTH), empty = (count==0).
REQ-024 SHALL, on flush, zero the pointers and count on the next edge, ignore any same-cycle push or pop, and leave overflow unchanged.
REQ-025 SHALL clear overflow only by reset.
REQ-026 SHALL, while en_queue is low, hold all registers; out_data and out_valid continue to reflect the held state.
REQ-027 SHALL not count a skip_zero discard as a drop.

Reset
REQ-028 SHALL, on reset_l low, clear the pointers, count, and overflow immediately and asynchronously: out_valid=0, empty=1, full=0, count=0.
REQ-029 SHALL not reset storage contents; out_data is don't-care while empty.
REQ-030 SHALL, on reset asserted mid-operation, lose all queued events with no partial state retained.

Configuration
REQ-031 SHALL implement macro SPIKE_QUEUE_DROP_CNT_EN:
- Defined: adds output drop_cnt, 8 bits, incremented per dropped event, saturating at 255, cleared by reset only.
- Undefined: port and counter are absent; overflow behaviour is unchanged.

Structure
REQ-032 SHALL place the event width constant (TEN_DATA_WIDTH+NEURON_ID_WIDTH) and the spike/id field offset constants in the shared neurosa package, for use by the upstream network and the downstream neuron update stage.
REQ-033 SHALL be a single module with no sub-module; storage is an inferred register array.

Verification
REQ-034 Verification SHALL cover single event: push {2'b01, id 7'd37} into the empty queue -> next cycle out_valid=1, out_data=9'b01_0100101, count=1; pop -> empty=1.
REQ-035 Verification SHALL cover fill and overflow: 9 pushes with out_ready=0 (depth 8) -> full=1 after the 8th, 9th event dropped, overflow=1, drop_cnt=1 when the macro is defined, and drain order matches the first 8 events.
REQ-036 Verification SHALL cover push plus pop while full: push and pop in the same cycle -> count stays 8, no overflow, new event emerges last.
REQ-037 Verification SHALL cover skip_zero: skip_zero=1, push spike value 0 -> count unchanged, overflow=0; with skip_zero=0 the same event is queued.
REQ-038 Verification SHALL cover enable and flush: en_queue=0 with ev_valid=1 and out_ready=1 -> count unchanged; flush with 5 entries -> count=0 next cycle, overflow held.
REQ-039 Verification SHALL cover async reset: reset_l asserted mid-drain between clock edges -> count=0 and out_valid=0 immediately, before the next edge.
